// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer that shares one combinational ALU between two requesters.
// It screens out illegal and divide-by-zero ops and returns tagged results on a single response channel.
module alu_share_arbiter #(
    parameter int W   = 8,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic [3:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_y,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic         rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] OP_DIV     = 4'h3;
    localparam logic [3:0] OP_MOD     = 4'h4;
    localparam logic [3:0] OP_ILLEGAL = 4'hA;
    localparam logic [3:0] CNT_LOAD   = 4'(LAT - 1);

    state_t         r_state;
    state_t         w_nextState;
    logic           r_lastGrant;
    logic [3:0]     r_cnt;
    logic [3:0]     r_aluOp;
    logic [W-1:0]   r_aluA;
    logic [W-1:0]   r_aluB;
    logic           r_rspId;
    logic [W-1:0]   r_rspResult;
    logic           r_rspErr;

    logic           w_grant0;
    logic           w_grant1;
    logic           w_accept;
    logic           w_selId;
    logic [3:0]     w_selOp;
    logic [W-1:0]   w_selA;
    logic [W-1:0]   w_selB;
    logic           w_reject;

    // On a tie the requester that did not win last time gets the grant.
    assign w_grant0 = req0_valid & (~req1_valid | r_lastGrant);
    assign w_grant1 = req1_valid & (~req0_valid | ~r_lastGrant);

    assign req0_ready = (r_state == IDLE) & w_grant0;
    assign req1_ready = (r_state == IDLE) & w_grant1;
    assign w_accept   = req0_ready | req1_ready;

    assign w_selId = w_grant1;
    assign w_selOp = w_grant1 ? req1_op : req0_op;
    assign w_selA  = w_grant1 ? req1_a  : req0_a;
    assign w_selB  = w_grant1 ? req1_b  : req0_b;

    assign w_reject = (w_selOp >= OP_ILLEGAL) |
                      (((w_selOp == OP_DIV) | (w_selOp == OP_MOD)) & (w_selB == '0));

    assign alu_op     = r_aluOp;
    assign alu_a      = r_aluA;
    assign alu_b      = r_aluB;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_rspId;
    assign rsp_result = r_rspResult;
    assign rsp_err    = r_rspErr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_reject ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (r_cnt == 4'd0) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Rejected ops never reach the ALU, so its inputs keep the last issued values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lastGrant <= 1'b1;
            r_cnt       <= 4'd0;
            r_aluOp     <= 4'd0;
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_rspId     <= 1'b0;
            r_rspResult <= '0;
            r_rspErr    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rspId     <= w_selId;
                        r_lastGrant <= w_selId;
                        if (w_reject) begin
                            r_rspErr    <= 1'b1;
                            r_rspResult <= '0;
                        end else begin
                            r_aluOp <= w_selOp;
                            r_aluA  <= w_selA;
                            r_aluB  <= w_selB;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_rspResult <= alu_y;
                        r_rspErr    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the shared datapath.
module tb_alu_share_arbiter;

    localparam int W   = 8;
    localparam int LAT = 2;

    logic         clk;
    logic         rst_n;
    logic         req0_valid;
    logic         req0_ready;
    logic [3:0]   req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [3:0]   req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_y;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_err;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(.W(W), .LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_y      (alu_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR.
    always_comb begin
        alu_y = '0;
        case (alu_op)
            4'h0: alu_y = alu_a + alu_b;
            4'h1: alu_y = alu_a - alu_b;
            4'h2: alu_y = alu_a * alu_b;
            4'h3: alu_y = (alu_b != '0) ? alu_a / alu_b : '0;
            4'h4: alu_y = (alu_b != '0) ? alu_a % alu_b : '0;
            4'h5: alu_y = alu_a & alu_b;
            4'h6: alu_y = alu_a | alu_b;
            4'h7: alu_y = alu_a ^ alu_b;
            default: alu_y = '0;
        endcase
    end

    logic [3:0]   op0Tab  [4] = '{4'h2, 4'h0, 4'h5, 4'h2};
    logic [W-1:0] a0Tab   [4] = '{8'h03, 8'h10, 8'hF0, 8'h10};
    logic [W-1:0] b0Tab   [4] = '{8'h04, 8'h20, 8'h3C, 8'h10};
    logic [W-1:0] exp0Tab [4] = '{8'h0C, 8'h30, 8'h30, 8'h00};
    logic [3:0]   op1Tab  [4] = '{4'h1, 4'h6, 4'h7, 4'h1};
    logic [W-1:0] a1Tab   [4] = '{8'h09, 8'h0F, 8'hAA, 8'h00};
    logic [W-1:0] b1Tab   [4] = '{8'h02, 8'hF0, 8'hFF, 8'h01};
    logic [W-1:0] exp1Tab [4] = '{8'h07, 8'hFF, 8'h55, 8'hFF};

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic which, input logic valid, input logic [3:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        if (which) begin
            req1_valid = valid;
            req1_op    = op;
            req1_a     = a;
            req1_b     = b;
        end else begin
            req0_valid = valid;
            req0_op    = op;
            req0_a     = a;
            req0_b     = b;
        end
    endtask

    task automatic waitResp(output int n);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int i0;
        int i1;
        logic g;
        logic [W-1:0] expRes;
        logic [W-1:0] expA;

        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
        checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
        checkOutput("rst_rsp_result", 32'(rsp_result), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);

        // Single ADD from requester 0 with exact latency.
        applyStimulus(1'b0, 1'b1, 4'h0, 8'h05, 8'h03);
        #1;
        checkOutput("add_ready0", 32'(req0_ready), 32'd1);
        checkOutput("add_ready1", 32'(req1_ready), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
        checkOutput("add_alu_a", 32'(alu_a), 32'h05);
        checkOutput("add_alu_b", 32'(alu_b), 32'h03);
        checkOutput("add_c1_valid", 32'(rsp_valid), 32'd0);
        tick();
        checkOutput("add_c2_valid", 32'(rsp_valid), 32'd0);
        tick();
        checkOutput("add_c3_valid", 32'(rsp_valid), 32'd1);
        checkOutput("add_id", 32'(rsp_id), 32'd0);
        checkOutput("add_result", 32'(rsp_result), 32'h08);
        checkOutput("add_err", 32'(rsp_err), 32'd0);
        tick();
        checkOutput("add_done_valid", 32'(rsp_valid), 32'd0);

        // Fairness: both requesters contend for four ops each.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        i0 = 0;
        i1 = 0;
        applyStimulus(1'b0, 1'b1, op0Tab[0], a0Tab[0], b0Tab[0]);
        applyStimulus(1'b1, 1'b1, op1Tab[0], a1Tab[0], b1Tab[0]);
        for (int k = 0; k < 8; k++) begin
            g = k[0];
            #1;
            checkOutput("rr_ready0", 32'(req0_ready), 32'(!g));
            checkOutput("rr_ready1", 32'(req1_ready), 32'(g));
            expRes = g ? exp1Tab[i1] : exp0Tab[i0];
            expA   = g ? a1Tab[i1] : a0Tab[i0];
            tick();
            if (g) i1++; else i0++;
            if (i0 < 4) applyStimulus(1'b0, 1'b1, op0Tab[i0], a0Tab[i0], b0Tab[i0]);
            else        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
            if (i1 < 4) applyStimulus(1'b1, 1'b1, op1Tab[i1], a1Tab[i1], b1Tab[i1]);
            else        applyStimulus(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
            #1;
            checkOutput("rr_exec_ready", 32'(req0_ready | req1_ready), 32'd0);
            checkOutput("rr_alu_a_held", 32'(alu_a), 32'(expA));
            waitResp(n);
            checkOutput("rr_latency", 32'(n), 32'd2);
            checkOutput("rr_id", 32'(rsp_id), 32'(g));
            checkOutput("rr_result", 32'(rsp_result), 32'(expRes));
            checkOutput("rr_err", 32'(rsp_err), 32'd0);
            tick();
        end

        // Divide by zero is rejected without issuing to the ALU.
        applyStimulus(1'b1, 1'b1, 4'h3, 8'h10, 8'h00);
        #1;
        checkOutput("div0_ready1", 32'(req1_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
        checkOutput("div0_valid", 32'(rsp_valid), 32'd1);
        checkOutput("div0_err", 32'(rsp_err), 32'd1);
        checkOutput("div0_result", 32'(rsp_result), 32'd0);
        checkOutput("div0_id", 32'(rsp_id), 32'd1);
        checkOutput("div0_alu_op", 32'(alu_op), 32'h1);
        checkOutput("div0_alu_a", 32'(alu_a), 32'h00);
        checkOutput("div0_alu_b", 32'(alu_b), 32'h01);
        tick();

        // Divisor with only the top bit set is nonzero and must be issued.
        applyStimulus(1'b1, 1'b1, 4'h3, 8'h10, 8'h80);
        tick();
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
        waitResp(n);
        checkOutput("divmsb_latency", 32'(n), 32'd2);
        checkOutput("divmsb_err", 32'(rsp_err), 32'd0);
        checkOutput("divmsb_alu_b", 32'(alu_b), 32'h80);
        tick();

        // Illegal opcodes 4'hC and 4'hA.
        applyStimulus(1'b0, 1'b1, 4'hC, 8'h11, 8'h22);
        tick();
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
        checkOutput("opC_valid", 32'(rsp_valid), 32'd1);
        checkOutput("opC_err", 32'(rsp_err), 32'd1);
        checkOutput("opC_id", 32'(rsp_id), 32'd0);
        checkOutput("opC_alu_op", 32'(alu_op), 32'h3);
        tick();
        applyStimulus(1'b0, 1'b1, 4'hA, 8'h11, 8'h22);
        tick();
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
        checkOutput("opA_valid", 32'(rsp_valid), 32'd1);
        checkOutput("opA_err", 32'(rsp_err), 32'd1);
        tick();

        // Consumer back-pressure holds the response and blocks new grants.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 1'b1, 4'h0, 8'h01, 8'h02);
        tick();
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b1, 4'h0, 8'h02, 8'h02);
        waitResp(n);
        checkOutput("hold_latency", 32'(n), 32'd2);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_result", 32'(rsp_result), 32'h03);
            checkOutput("hold_ready", 32'(req0_ready | req1_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("hold_hs_ready", 32'(req0_ready | req1_ready), 32'd0);
        tick();
        checkOutput("hold_release_valid", 32'(rsp_valid), 32'd0);
        checkOutput("hold_next_ready1", 32'(req1_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
        waitResp(n);
        checkOutput("hold_next_result", 32'(rsp_result), 32'h04);
        checkOutput("hold_next_id", 32'(rsp_id), 32'd1);
        tick();

        // Reset during execution of an XOR aborts it.
        applyStimulus(1'b1, 1'b1, 4'h7, 8'h0F, 8'h33);
        tick();
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
        checkOutput("xor_issued", 32'(alu_op), 32'h7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_alu_op", 32'(alu_op), 32'd0);
        checkOutput("abort_alu_a", 32'(alu_a), 32'd0);
        checkOutput("abort_alu_b", 32'(alu_b), 32'd0);
        checkOutput("abort_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("abort_rsp_result", 32'(rsp_result), 32'd0);
        checkOutput("abort_rsp_err", 32'(rsp_err), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h0, 8'h07, 8'h08);
        applyStimulus(1'b1, 1'b1, 4'h0, 8'h01, 8'h01);
        #1;
        checkOutput("post_rst_ready0", 32'(req0_ready), 32'd1);
        checkOutput("post_rst_ready1", 32'(req1_ready), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
        waitResp(n);
        checkOutput("post_rst_latency", 32'(n), 32'd2);
        checkOutput("post_rst_result", 32'(rsp_result), 32'h0F);
        checkOutput("post_rst_id", 32'(rsp_id), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
